e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets).
REQ-003 SHALL have port: E_MDUStart  input  1  E-stage instruction is a mult/div; sampled each edge.
REQ-004 SHALL have port: E_MDUOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-005 SHALL have port: E_A  input  32  forwarded rs operand.
REQ-006 SHALL have port: E_B  input  32  forwarded rt operand.
REQ-007 SHALL have port: E_MDUBusy  output  1  operation in progress.
REQ-008 SHALL have port: E_MDUStall  output  1  E_MDUStart | E_MDUBusy; consumed by the hazard unit to hold D.
REQ-009 SHALL have port: E_MDUResult  output  32  HI when op==MFHI, LO when op==MFLO, else 0 (combinational).
REQ-010 SHALL have port: HI  output  32  HI register value.
REQ-011 SHALL have port: LO  output  32  LO register value.

Function
REQ-012 SHALL accept a new operation at an edge only when E_MDUStart==1, op in {1..4} and E_MDUBusy==0; otherwise E_MDUStart is ignored.
REQ-013 SHALL latch E_A, E_B and op at the accepting edge; later operand changes do not affect the result.
REQ-014 SHALL hold E_MDUBusy=1 for exactly 5 cycles after accepting MULT/MULTU and 10 cycles after accepting DIV/DIVU.
REQ-015 SHALL update HI/LO at the same edge on which E_MDUBusy falls; no intermediate HI/LO values are visible.
REQ-016 MULT: {HI,LO} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-017 DIV: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU: unsigned quotient/remainder.
REQ-018 SHALL leave HI/LO unchanged at completion of DIV/DIVU whose latched divisor is 0; busy timing is unchanged.
REQ-019 DIV with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 MTHI/MTLO SHALL write E_A to HI/LO at the next edge when E_MDUBusy==0; they SHALL be ignored while busy (the hazard unit guarantees they are never issued then).
REQ-021 MFHI/MFLO SHALL return the current registered HI/LO; they take no cycles and do not change state.
REQ-022 SHALL use a two-state FSM IDLE/BUSY with a 4-bit down-counter: IDLE->BUSY on accept (counter loads 5 or 10); BUSY decrements every edge; BUSY->IDLE when counter reaches 0, which also commits HI/LO.
REQ-023 E_MDUBusy SHALL be registered (high exactly while in BUSY); E_MDUStall SHALL be combinational.
REQ-024 A start at the completing edge SHALL be ignored (busy still 1); the same instruction is accepted on the following edge because E_MDUStall holds it.

Reset
REQ-025 On reset==0 at an edge: FSM=IDLE, counter=0, HI=0, LO=0, latched operands=0, E_MDUBusy=0.
REQ-026 Reset mid-operation SHALL abort the operation without committing HI/LO; reset takes priority over all other inputs.

Configuration
REQ-027 Macro MDU_DIV_EN defined: DIV/DIVU behave per REQ-014/017/018/019.
REQ-028 Macro MDU_DIV_EN undefined: ops 3/4 treated as NONE (not accepted, no busy, HI/LO unchanged) and no divider logic is synthesized; all other behaviour identical.

Verification
REQ-029 MULT A=0xFFFFFFFE(-2), B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO keep prior values after 10 busy cycles.
REQ-031 MTHI A=0x12345678 then MFHI -> E_MDUResult=0x12345678 the next cycle; MTLO while busy -> LO unchanged.
REQ-032 MULT accepted, operands changed during busy, second start asserted at completing edge -> result uses original operands; second op accepted one edge later.
REQ-033 Reset driven low at busy cycle 3 of a DIV -> next cycle busy=0, HI=LO=0, no later commit.
REQ-034 Build without MDU_DIV_EN, issue DIV 10/3 -> E_MDUBusy stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers and a multi-cycle IDLE/BUSY sequencer.
// Define MDU_DIV_EN to build DIV/DIVU support; without it ops 3/4 behave as NONE.
module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MDUStart,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MDUBusy,
  output logic        E_MDUStall,
  output logic [31:0] E_MDUResult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [DATA_W-1:0] ONE = 1;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [3:0]                cnt;
  logic [3:0]                op_p0;
  logic signed [DATA_W-1:0]  a_p0;
  logic signed [DATA_W-1:0]  b_p0;

  logic                      is_mul;
  logic                      is_div;
  logic                      accept;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]       prod_u;

  assign is_mul = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
`ifdef MDU_DIV_EN
  assign is_div = (E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign accept = E_MDUStart && !E_MDUBusy && (is_mul || is_div);

  assign E_MDUStall = E_MDUStart | E_MDUBusy;

  always_comb begin
    E_MDUResult = '0;
    if (E_MDUOp == OP_MFHI)
      E_MDUResult = HI;
    else if (E_MDUOp == OP_MFLO)
      E_MDUResult = LO;
  end

  // Stage p0 -> commit: results formed from operands latched at accept
  assign prod_s = $signed({{DATA_W{a_p0[DATA_W-1]}}, a_p0}) *
                  $signed({{DATA_W{b_p0[DATA_W-1]}}, b_p0});
  assign prod_u = {{DATA_W{1'b0}}, a_p0} * {{DATA_W{1'b0}}, b_p0};

`ifdef MDU_DIV_EN
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  logic              div_signed;
  logic              div_zero;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W-1:0] dvs_safe;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  // Divide magnitudes unsigned, then restore signs; this makes
  // 0x80000000 / -1 wrap to 0x80000000 without a special case.
  assign div_signed = (op_p0 == OP_DIV);
  assign div_zero   = (b_p0 == '0);
  assign dvd_mag    = apply_sign(a_p0, div_signed & a_p0[DATA_W-1]);
  assign dvs_mag    = apply_sign(b_p0, div_signed & b_p0[DATA_W-1]);
  assign dvs_safe   = div_zero ? ONE : dvs_mag;
  assign q_mag      = dvd_mag / dvs_safe;
  assign r_mag      = dvd_mag % dvs_safe;
  assign quo        = apply_sign(q_mag, div_signed & (a_p0[DATA_W-1] ^ b_p0[DATA_W-1]));
  assign rem        = apply_sign(r_mag, div_signed & a_p0[DATA_W-1]);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      HI        <= '0;
      LO        <= '0;
      E_MDUBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            E_MDUBusy <= 1'b1;
            cnt       <= is_div ? 4'd10 : 4'd5;
            op_p0     <= E_MDUOp;
            a_p0      <= E_A;
            b_p0      <= E_B;
          end else if (E_MDUOp == OP_MTHI) begin
            HI <= E_A;
          end else if (E_MDUOp == OP_MTLO) begin
            LO <= E_A;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state     <= IDLE;
            E_MDUBusy <= 1'b0;
            cnt       <= '0;
            case (op_p0)
              OP_MULT:  {HI, LO} <= prod_s;
              OP_MULTU: {HI, LO} <= prod_u;
`ifdef MDU_DIV_EN
              OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                  LO <= quo;
                  HI <= rem;
                end
              end
`endif
              default: ;
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at issue, checked when busy falls.
module tb_e_mdu;
  logic        clk;
  logic        reset;
  logic        E_MDUStart;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_MDUBusy;
  logic        E_MDUStall;
  logic [31:0] E_MDUResult;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu dut (
    .clk(clk), .reset(reset), .E_MDUStart(E_MDUStart), .E_MDUOp(E_MDUOp),
    .E_A(E_A), .E_B(E_B), .E_MDUBusy(E_MDUBusy), .E_MDUStall(E_MDUStall),
    .E_MDUResult(E_MDUResult), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates the modelled HI/LO and queues the expectation.
  task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa;
    longint      sd;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    e.cyc = 5;
    case (op)
      4'd1: begin p = sa * sd; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: begin
        e.cyc = 10;
        if (b != 0) begin
          p = sa / sd; m_lo = p[31:0];
          p = sa % sd; m_hi = p[31:0];
        end
      end
      4'd4: begin
        e.cyc = 10;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    E_MDUStart = 1'b1;
    E_MDUOp    = op;
    E_A        = a;
    E_B        = b;
    push_exp(op, a, b);
    tick();
    E_MDUStart = 1'b0;
    E_MDUOp    = 4'd0;
  endtask

  task automatic drain(input string name);
    exp_t        e;
    int          n;
    logic        held;
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = HI; l0 = LO; held = 1'b1; n = 0;
    while (E_MDUBusy === 1'b1 && n < 40) begin
      n++;
      if (HI !== h0 || LO !== l0) held = 1'b0;
      tick();
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
      return;
    end
    e = sb.pop_front();
    if (n !== e.cyc) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, e.cyc);
    end
    vectors++;
    if (held !== 1'b1) begin
      miscompares++;
      $display("FAIL %s hilo_hold: got %b expected 1", name, held);
    end
    vectors++;
    if (HI !== e.hi) begin
      miscompares++;
      $display("FAIL %s HI: got %h expected %h", name, HI, e.hi);
    end
    vectors++;
    if (LO !== e.lo) begin
      miscompares++;
      $display("FAIL %s LO: got %h expected %h", name, LO, e.lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; E_MDUStart = 1'b0; E_MDUOp = 4'd5; E_A = '0; E_B = '0;
    tick(); tick();
    vectors++;
    if (E_MDUBusy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", E_MDUBusy); end
    vectors++;
    if (E_MDUStall !== 1'b0) begin miscompares++; $display("FAIL reset stall: got %b expected 0", E_MDUStall); end
    vectors++;
    if (HI !== 32'h0) begin miscompares++; $display("FAIL reset HI: got %h expected 0", HI); end
    vectors++;
    if (LO !== 32'h0) begin miscompares++; $display("FAIL reset LO: got %h expected 0", LO); end
    vectors++;
    if (E_MDUResult !== 32'h0) begin miscompares++; $display("FAIL reset mfhi: got %h expected 0", E_MDUResult); end
    reset = 1'b1; E_MDUOp = 4'd0; m_hi = '0; m_lo = '0;
    tick();
  endtask

  task automatic test_mult;
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    vectors++;
    if (E_MDUStall !== 1'b1) begin miscompares++; $display("FAIL mult stall: got %b expected 1", E_MDUStall); end
    drain("mult");
    issue(4'd2, 32'hFFFFFFFE, 32'd3);
    drain("multu");
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom; rb = $urandom;
      issue((i % 2 == 0) ? 4'd1 : 4'd2, ra, rb);
      drain("mult_rand");
    end
  endtask

  task automatic test_moves;
    E_MDUOp = 4'd7; E_A = 32'h12345678; tick();
    m_hi = 32'h12345678;
    E_MDUOp = 4'd5; #1;
    vectors++;
    if (E_MDUResult !== 32'h12345678) begin miscompares++; $display("FAIL mfhi: got %h expected 12345678", E_MDUResult); end
    E_MDUOp = 4'd8; E_A = 32'hCAFEF00D; tick();
    m_lo = 32'hCAFEF00D;
    E_MDUOp = 4'd6; #1;
    vectors++;
    if (E_MDUResult !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mflo: got %h expected cafef00d", E_MDUResult); end
    E_MDUOp = 4'd9; #1;
    vectors++;
    if (E_MDUResult !== 32'h0) begin miscompares++; $display("FAIL op9_result: got %h expected 0", E_MDUResult); end
    E_MDUOp = 4'd5; E_A = 32'hFFFF0000; tick();
    vectors++;
    if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL mfhi_nostate: got %h/%h expected 12345678/cafef00d", HI, LO);
    end
    E_MDUOp = 4'd0;
  endtask

  task automatic test_ignored_start;
    E_MDUStart = 1'b1; E_MDUOp = 4'd0; #1;
    vectors++;
    if (E_MDUStall !== 1'b1) begin miscompares++; $display("FAIL stall_comb: got %b expected 1", E_MDUStall); end
    tick();
    E_MDUOp = 4'd9; tick();
    vectors++;
    if (E_MDUBusy !== 1'b0) begin miscompares++; $display("FAIL none_start busy: got %b expected 0", E_MDUBusy); end
    E_MDUStart = 1'b0; E_MDUOp = 4'd0; #1;
    vectors++;
    if (E_MDUStall !== 1'b0) begin miscompares++; $display("FAIL stall_idle: got %b expected 0", E_MDUStall); end
  endtask

  task automatic test_mtlo_busy;
    issue(4'd1, 32'd6, 32'd7);
    E_MDUOp = 4'd8; E_A = 32'hDEADBEEF;
    drain("mtlo_busy");
    E_MDUOp = 4'd0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    E_MDUStart = 1'b1; E_MDUOp = 4'd1; E_A = 32'd5; E_B = 32'd7;
    push_exp(4'd1, 32'd5, 32'd7);
    tick();
    E_MDUStart = 1'b0; E_MDUOp = 4'd0; E_A = 32'd100; E_B = 32'd200;
    tick(); tick(); tick(); tick();
    vectors++;
    if (E_MDUBusy !== 1'b1) begin miscompares++; $display("FAIL b2b busy_c5: got %b expected 1", E_MDUBusy); end
    E_MDUStart = 1'b1; E_MDUOp = 4'd2;
    tick();
    vectors++;
    if (E_MDUBusy !== 1'b0) begin miscompares++; $display("FAIL b2b busy_fall: got %b expected 0", E_MDUBusy); end
    vectors++;
    if (E_MDUStall !== 1'b1) begin miscompares++; $display("FAIL b2b stall: got %b expected 1", E_MDUStall); end
    e = sb.pop_front();
    vectors++;
    if (HI !== e.hi || LO !== e.lo) begin
      miscompares++; $display("FAIL b2b first: got %h/%h expected %h/%h", HI, LO, e.hi, e.lo);
    end
    push_exp(4'd2, 32'd100, 32'd200);
    tick();
    E_MDUStart = 1'b0; E_MDUOp = 4'd0;
    vectors++;
    if (E_MDUBusy !== 1'b1) begin miscompares++; $display("FAIL b2b second_accept: got %b expected 1", E_MDUBusy); end
    drain("b2b_second");
  endtask

  task automatic test_reset_abort;
`ifdef MDU_DIV_EN
    logic [3:0] op = 4'd3;
`else
    logic [3:0] op = 4'd1;
`endif
    E_MDUOp = 4'd7; E_A = 32'h11111111; tick();
    E_MDUStart = 1'b1; E_MDUOp = op; E_A = 32'hFFFFFFF9; E_B = 32'd2;
    tick();
    E_MDUStart = 1'b0; E_MDUOp = 4'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (E_MDUBusy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      miscompares++; $display("FAIL abort: got busy=%b %h/%h expected 0 0/0", E_MDUBusy, HI, LO);
    end
    reset = 1'b1; m_hi = '0; m_lo = '0;
    repeat (12) tick();
    vectors++;
    if (E_MDUBusy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      miscompares++; $display("FAIL abort_late: got busy=%b %h/%h expected 0 0/0", E_MDUBusy, HI, LO);
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    drain("div_neg");
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    drain("div_ovf");
    issue(4'd4, 32'd7, 32'd0);
    drain("divu_zero");
    issue(4'd3, 32'd100, 32'hFFFFFFF9);
    drain("div_negdvs");
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom; rb = $urandom_range(1, 1000);
      issue((i % 2 == 0) ? 4'd4 : 4'd3, ra, rb);
      drain("div_rand");
    end
  endtask
`else
  task automatic test_div_disabled;
    E_MDUOp = 4'd7; E_A = 32'hA5A5A5A5; tick();
    E_MDUOp = 4'd8; E_A = 32'h5A5A5A5A; tick();
    E_MDUStart = 1'b1; E_MDUOp = 4'd3; E_A = 32'd10; E_B = 32'd3; #1;
    vectors++;
    if (E_MDUStall !== 1'b1) begin miscompares++; $display("FAIL nodiv stall: got %b expected 1", E_MDUStall); end
    tick();
    vectors++;
    if (E_MDUBusy !== 1'b0) begin miscompares++; $display("FAIL nodiv div_busy: got %b expected 0", E_MDUBusy); end
    E_MDUOp = 4'd4; tick();
    vectors++;
    if (E_MDUBusy !== 1'b0) begin miscompares++; $display("FAIL nodiv divu_busy: got %b expected 0", E_MDUBusy); end
    E_MDUStart = 1'b0; E_MDUOp = 4'd0;
    repeat (11) tick();
    vectors++;
    if (HI !== 32'hA5A5A5A5 || LO !== 32'h5A5A5A5A) begin
      miscompares++; $display("FAIL nodiv hilo: got %h/%h expected a5a5a5a5/5a5a5a5a", HI, LO);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_moves();
    test_ignored_start();
    test_mtlo_busy();
    test_back_to_back();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
